spi_mem_arbiter: RTL

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

---
 rtl/spi_mem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_mem_arbiter.sv
// Arbiter that shares one SPI memory engine between the instruction-fetch
// port and the data port. The arbiter grants one requester at a time and
// holds the latched command steady while the engine works. It returns the
// read byte, or a timeout error, with a single-cycle acknowledge.
module spi_mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [7:0]  d_wdata,
    output logic        f_ack,
    output logic        d_ack,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        spi_start,
    output logic        spi_write,
    output logic [15:0] spi_addr,
    output logic [7:0]  spi_wdata,
    input  logic        spi_done,
    input  logic [7:0]  spi_rdata,
    input  logic        spi_cs,
    output logic        cs_rom,
    output logic        cs_ram
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    owner_t      lastGrant_q, lastGrant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        grantData;

    // State and datapath registers. Reset parks the arbiter in IDLE with
    // fetch recorded as the last grant, so data wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_FETCH;
            lastGrant_q <= OWN_FETCH;
            cnt_q       <= 8'd0;
            addr_q      <= 16'd0;
            we_q        <= 1'b0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: round-robin grant in IDLE, and completion or
    // timeout in BUSY. A done in the final timeout cycle still counts as
    // success. The RESP state lasts exactly one cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        grantData   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (f_req || d_req) begin
                    grantData   = d_req && (!f_req || (lastGrant_q == OWN_FETCH));
                    owner_d     = grantData ? OWN_DATA : OWN_FETCH;
                    lastGrant_d = grantData ? OWN_DATA : OWN_FETCH;
                    cnt_d       = 8'd0;
                    if (grantData) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = f_addr;
                        we_d    = 1'b0;
                        wdata_d = 8'd0;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (spi_done) begin
                    rdata_d = we_q ? 8'h00 : spi_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == (TIMEOUT - 8'd1)) begin
                    rdata_d = 8'hFF;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign spi_start = (state_q == ST_BUSY);
    assign spi_write = we_q;
    assign spi_addr  = addr_q;
    assign spi_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign f_ack     = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
    assign d_ack     = (state_q == ST_RESP) && (owner_q == OWN_DATA);
    assign cs_rom    = ((state_q == ST_BUSY) && (owner_q == OWN_FETCH)) ? spi_cs : 1'b1;
    assign cs_ram    = ((state_q == ST_BUSY) && (owner_q == OWN_DATA))  ? spi_cs : 1'b1;

endmodule
